// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter/sequencer for the single-port ram; ARB_FIXED_PRIO_EN selects fixed m0 priority.
// Latency: gnt in cycle N, ram access in N+1, registered ack/rdata in N+2 (one access per 2 cycles).
// Backpressure: a master holds req/we/adr/wdata until gnt; no grant is issued while an access is in flight.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module ram_arbiter #(
    parameter int ADR_W  = 4,
    parameter int DATA_W = `DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADR_W-1:0]  m0_adr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADR_W-1:0]  m1_adr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_we,
    output logic [ADR_W-1:0]  ram_adr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADR_W-1:0]    cmd_adr_q, cmd_adr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                cmd_id_q, cmd_id_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                any_req;
    logic                pick1;
    logic                grant;
    logic                read_done;

    assign any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = m1_req & ~m0_req;
`else
    // On a tie, the master that did not win last time gets the slot.
    assign pick1 = m1_req & (~m0_req | ~last_gnt_q);
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gated by rst so grants and the RAM write strobe drop the moment reset rises.
    always_comb begin
        grant  = 1'b0;
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        ram_we = 1'b0;
        case (state_q)
            IDLE: begin
                grant  = any_req & ~rst;
                m0_gnt = grant & ~pick1;
                m1_gnt = grant & pick1;
            end
            ACCESS: begin
                ram_we = cmd_we_q & ~rst;
            end
            default: ;
        endcase
    end

    // ---------------- datapath next state ----------------
    assign read_done = (state_q == ACCESS) & ~cmd_we_q;

    always_comb begin
        last_gnt_d  = last_gnt_q;
        cmd_we_d    = cmd_we_q;
        cmd_adr_d   = cmd_adr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_id_d    = cmd_id_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        if (grant) begin
            cmd_id_d    = pick1;
            last_gnt_d  = pick1;
            cmd_we_d    = pick1 ? m1_we    : m0_we;
            cmd_adr_d   = pick1 ? m1_adr   : m0_adr;
            cmd_wdata_d = pick1 ? m1_wdata : m0_wdata;
        end

        if (read_done && !cmd_id_q) m0_rdata_d = ram_dout;
        if (read_done &&  cmd_id_q) m1_rdata_d = ram_dout;

        m0_ack_d = (state_q == ACCESS) & ~cmd_id_q;
        m1_ack_d = (state_q == ACCESS) &  cmd_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_adr_q   <= '0;
            cmd_wdata_q <= '0;
            cmd_id_q    <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            cmd_we_q    <= cmd_we_d;
            cmd_adr_q   <= cmd_adr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_id_q    <= cmd_id_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // The command registers only move at a grant, so in IDLE the RAM address/data hold the last access.
    assign ram_adr  = cmd_adr_q;
    assign ram_din  = cmd_wdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural sync-write/async-read RAM; honours ARB_FIXED_PRIO_EN.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0] m0_adr = 0, m1_adr = 0;
    logic [7:0] m0_wdata = 0, m1_wdata = 0;
    logic       m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic       ram_we;
    logic [3:0] ram_adr;
    logic [7:0] ram_din, ram_dout;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_adr] <= ram_din;
    assign ram_dout = mem[ram_adr];

    ram_arbiter #(.ADR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1, checks happen at posedge+2.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic r, input logic we,
                           input logic [3:0] adr, input logic [7:0] wd);
        if (id == 0) begin
            m0_req = r; m0_we = we; m0_adr = adr; m0_wdata = wd;
        end else begin
            m1_req = r; m1_we = we; m1_adr = adr; m1_wdata = wd;
        end
    endtask

    // Single uncontended access: gnt at N, ram drive at N+1, ack (and rdata) at N+2.
    task automatic do_access(input string tag, input int id, input logic we,
                             input logic [3:0] adr, input logic [7:0] wd, input logic [7:0] exp_rd);
        set_req(id, 1'b1, we, adr, wd);
        #1;
        chk({tag, ".gnt"}, (id == 0) ? m0_gnt : m1_gnt, 1);
        chk({tag, ".other_gnt"}, (id == 0) ? m1_gnt : m0_gnt, 0);
        @(posedge clk);
        #1;
        set_req(id, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        chk({tag, ".ram_we"}, ram_we, we);
        chk({tag, ".ram_adr"}, ram_adr, adr);
        if (we) chk({tag, ".ram_din"}, ram_din, wd);
        chk({tag, ".no_gnt_in_access"}, m0_gnt | m1_gnt, 0);
        tick();
        chk({tag, ".ack"}, (id == 0) ? m0_ack : m1_ack, 1);
        chk({tag, ".other_ack"}, (id == 0) ? m1_ack : m0_ack, 0);
        if (!we) chk({tag, ".rdata"}, (id == 0) ? m0_rdata : m1_rdata, exp_rd);
        tick();
        chk({tag, ".ack_pulse"}, (id == 0) ? m0_ack : m1_ack, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.m0_gnt", m0_gnt, 0);
        chk("rst.m1_gnt", m1_gnt, 0);
        chk("rst.acks", {m0_ack, m1_ack}, 0);
        chk("rst.m0_rdata", m0_rdata, 0);
        chk("rst.m1_rdata", m1_rdata, 0);
        chk("rst.ram_we", ram_we, 0);
        tick();
        rst = 1'b0;
        tick();

        // m0 write then read-back
        do_access("m0_wr55", 0, 1'b1, 4'h5, 8'h55, 8'h00);
        do_access("m0_rd55", 0, 1'b0, 4'h5, 8'h00, 8'h55);

        // Preload via m1, then m1 read while m0 idle
        do_access("m1_wrA5", 1, 1'b1, 4'hA, 8'hA5, 8'h00);
        do_access("m1_wr11", 1, 1'b1, 4'h3, 8'h11, 8'h00);
        do_access("m1_rdA5", 1, 1'b0, 4'hA, 8'h00, 8'hA5);
        chk("m1_rd.m0_rdata_kept", m0_rdata, 8'h55);

        // Reset during the ACCESS cycle of an m1 write
        set_req(1, 1'b1, 1'b1, 4'h3, 8'hFF);
        #1;
        chk("rstacc.gnt", m1_gnt, 1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        chk("rstacc.ram_we_before", ram_we, 1);
        set_req(0, 1'b1, 1'b0, 4'h5, 8'h00);
        rst = 1'b1;
        #1;
        chk("rstacc.ram_we_async", ram_we, 0);
        chk("rstacc.gnt_blocked", m0_gnt | m1_gnt, 0);
        chk("rstacc.m0_rdata", m0_rdata, 0);
        chk("rstacc.m1_rdata", m1_rdata, 0);
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        chk("rstacc.no_ack", {m0_ack, m1_ack}, 0);
        #1;
        rst = 1'b0;
        tick();
        chk("rstacc.no_ack_after", {m0_ack, m1_ack}, 0);
        do_access("rstacc.rd3", 0, 1'b0, 4'h3, 8'h00, 8'h11);

        // Both masters reading continuously from reset
        rst = 1'b1;
        tick();
        #1;
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'h5, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'hA, 8'h00);
        #1;
        for (int c = 0; c < 8; c++) begin
            logic e_g0, e_g1, e_a0, e_a1;
`ifdef ARB_FIXED_PRIO_EN
            e_g0 = (c % 2 == 0);
            e_g1 = 1'b0;
            e_a0 = (c >= 2) && (c % 2 == 0);
            e_a1 = 1'b0;
`else
            e_g0 = (c % 2 == 0) && ((c / 2) % 2 == 0);
            e_g1 = (c % 2 == 0) && ((c / 2) % 2 == 1);
            e_a0 = (c >= 2) && (c % 2 == 0) && (((c / 2) - 1) % 2 == 0);
            e_a1 = (c >= 2) && (c % 2 == 0) && (((c / 2) - 1) % 2 == 1);
`endif
            chk($sformatf("fair.c%0d.m0_gnt", c), m0_gnt, e_g0);
            chk($sformatf("fair.c%0d.m1_gnt", c), m1_gnt, e_g1);
            chk($sformatf("fair.c%0d.m0_ack", c), m0_ack, e_a0);
            chk($sformatf("fair.c%0d.m1_ack", c), m1_ack, e_a1);
            chk($sformatf("fair.c%0d.both_gnt", c), m0_gnt & m1_gnt, 0);
            if (e_a0) chk($sformatf("fair.c%0d.m0_rdata", c), m0_rdata, 8'h55);
            if (e_a1) chk($sformatf("fair.c%0d.m1_rdata", c), m1_rdata, 8'hA5);
            tick();
        end

        // m0 drops: m1 must get the next slot
        #1;
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        chk("drop.m0_gnt", m0_gnt, 0);
        chk("drop.m1_gnt", m1_gnt, 1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        chk("drop.m1_ack", m1_ack, 1);
        chk("drop.m1_rdata", m1_rdata, 8'hA5);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port `ram` (sync write, async read).
- Master 0 is instruction fetch; master 1 is load/store. Both are general read/write ports.
- Serialises accesses round-robin, drives the RAM port from registered commands, and returns registered read data with an ack pulse.
- Sits between the CPU core and `ram` in the minicpu top level.

Parameters:
- ADR_W, 4, RAM address width; matches `ram`.
- DATA_W, `DATA_WIDTH (8), data word width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  master 0 request.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_adr  input  ADR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_gnt  output  1  master 0 request accepted this cycle (combinational).
- m0_ack  output  1  master 0 access complete; one-cycle pulse.
- m0_rdata  output  DATA_W  master 0 read data, registered.
- m1_req, m1_we, m1_adr, m1_wdata, m1_gnt, m1_ack, m1_rdata: same as m0_* for master 1.
- ram_we  output  1  to ram.we.
- ram_adr  output  ADR_W  to ram.adr.
- ram_din  output  DATA_W  to ram.din.
- ram_dout  input  DATA_W  from ram.dout (async read).

Behaviour:
- States: IDLE, ACCESS.
- Reset values: state=IDLE, last_gnt=1 (master 0 preferred first), cmd regs 0, mX_ack=0, mX_rdata=0. ram_we=0 combinationally while rst is high.
- Outputs in IDLE:
  - mX_gnt is driven only in IDLE and only for the arbitration winner.
  - One request only: it wins.
  - Both requesting: winner is the master other than last_gnt.
  - No request: no gnt; stays in IDLE.
- Handshake:
  - Transfer occurs when req & gnt.
  - Requester holds we/adr/wdata stable while req=1 and gnt=0.
  - Requester may drop req or present a new request after gnt.
- Grant edge (cycle N): capture cmd_we, cmd_adr, cmd_wdata, cmd_id; update last_gnt=cmd_id; go to ACCESS.
- ACCESS (cycle N+1):
  - ram_adr=cmd_adr, ram_din=cmd_wdata, ram_we=cmd_we.
  - No gnt is issued in ACCESS.
  - At the end edge the write commits in ram. For a read, ram_dout is captured into m{cmd_id}_rdata.
  - Then go to IDLE.
- IDLE: ram_we=0; ram_adr/ram_din hold their last values.
- Completion (cycle N+2): m{cmd_id}_ack=1 for exactly one cycle, for reads and writes.
  - A new grant may occur in the same cycle as the ack.
  - Peak throughput is one access per 2 cycles.
- mX_rdata holds its value until that master's next read completes; writes do not alter it.
- Fairness: under continuous requests from both masters, grants alternate strictly: 0,1,0,1...
- Reset in ACCESS: state returns to IDLE, the pending write is dropped (ram_we low before the edge), and no ack is issued.
- Both masters writing the same address back-to-back: the later grant's data wins.
- A read following a write to the same address returns the new data; the write commits before the read's ACCESS cycle.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Master 0 always wins when both request; last_gnt is still updated but ignored.
- Undefined (default): round-robin as above.

Test Plan:
- Reset: rst=1 mid-sequence → all gnt/ack=0, rdata=0, ram_we=0 immediately (async); state IDLE after release.
- m0 writes 8'h55 to adr 4'h5, then reads adr 4'h5 → m0_gnt at N, ram_we=1 at N+1, m0_ack at N+2; the read's ack carries m0_rdata=8'h55.
- m0 and m1 both assert req as reads, continuously for 8 cycles from reset → grants m0,m1,m0,m1; each ack 2 cycles after its gnt; no cycle with both gnt high.
- m1 reads adr 4'hA (preloaded 8'hA5) while m0 idle → m1_gnt at N, m1_ack at N+2 with m1_rdata=8'hA5; m0_ack stays 0 and m0_rdata unchanged.
- Reset asserted during ACCESS of an m1 write of 8'hFF to adr 4'h3 (prior 8'h11) → no m1_ack; a later read of adr 4'h3 returns 8'h11.
- With ARB_FIXED_PRIO_EN defined, both masters requesting continuously → m0 granted every grant slot; m1 granted only after m0_req drops.
